// File: rtl/polar_psum_collector_pkg.sv
// Shared types and helpers for the SC polar decoder partial-sum collector.
// The optional FROZEN_CHECK_EN feature lives in the top module.
package polar_psum_collector_pkg;

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} psum_state_e;

    localparam int N_MAX = 1024;

    // Width of the leaf counter for a code of length n (n/2 leaf visits)
    function automatic int leaf_cnt_w(input int n);
        return ($clog2(n / 2) < 1) ? 1 : $clog2(n / 2);
    endfunction

    // Reference x = u * G_N over GF(2) for the lower n bits of u
    function automatic logic [N_MAX-1:0] polar_xform(input logic [N_MAX-1:0] u, input int n);
        logic [N_MAX-1:0] x;
        x = u;
        for (int s = 1; s < n; s = s * 2) begin
            for (int j = 0; j < n; j++) begin
                if ((j & s) == 0) begin
                    x[j] = x[j] ^ x[j + s];
                end
            end
        end
        return x;
    endfunction

endpackage

// File: rtl/polar_psum_collector_if.sv
// Leaf-decision input channel and decoded-frame output channel of the collector.
interface polar_psum_collector_if #(
    parameter int N = 16
);
    logic         leaf_valid_i;
    logic [1:0]   leaf_bits_i;
    logic         leaf_ready_o;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [N-1:0] u_o;

    modport master (
        output leaf_valid_i, leaf_bits_i, out_ready_i,
        input  leaf_ready_o, out_valid_o, u_o
    );

    modport slave (
        input  leaf_valid_i, leaf_bits_i, out_ready_i,
        output leaf_ready_o, out_valid_o, u_o
    );
endinterface

// File: rtl/polar_psum_collector_butterfly.sv
// Combinational polar transform x = u * G_N, built as log2(N) XOR butterfly stages.
module polar_butterfly #(
    parameter int N = 16
) (
    input  logic [N-1:0] i_u,
    output logic [N-1:0] o_x
);
    localparam int STAGES = $clog2(N);

    logic [N-1:0] w_stage [0:STAGES];

    assign w_stage[0] = i_u;

    generate
        for (genvar gs = 0; gs < STAGES; gs++) begin : g_stage
            logic [N-1:0] w_nxt;
            for (genvar gi = 0; gi < N; gi++) begin : g_bit
                // Lower half of each butterfly folds in its partner at distance 2^gs
                if (((gi >> gs) % 2) == 0) begin : g_xor
                    assign w_nxt[gi] = w_stage[gs][gi] ^ w_stage[gs][gi + (1 << gs)];
                end else begin : g_pass
                    assign w_nxt[gi] = w_stage[gs][gi];
                end
            end
            assign w_stage[gs+1] = w_nxt;
        end
    endgenerate

    assign o_x = w_stage[STAGES];
endmodule

// File: rtl/polar_psum_collector.sv
// Collects leaf decisions into u_hat, keeps psum_o = u_hat * G_N registered, hands frames out.
// Optional FROZEN_CHECK_EN: sticky err_o when a frozen position receives a 1.
module polar_psum_collector
    import polar_psum_collector_pkg::*;
#(
    parameter int N = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic [N-1:0]           frozen_i,
    polar_psum_collector_if.slave  bus,
    output logic [N-1:0]           psum_o,
    output logic                   err_o
);
    localparam int LEAVES = N / 2;
    localparam int KW     = leaf_cnt_w(N);

    psum_state_e   r_state;
    psum_state_e   w_state_next;
    logic [KW-1:0] r_k;
    logic [N-1:0]  r_u;
    logic [N-1:0]  r_frozen;
    logic [N-1:0]  r_psum;
    logic [N-1:0]  w_u_next;
    logic [N-1:0]  w_x_next;
    logic          w_transfer;
    logic          w_last;
    logic          w_leaf_ready;
    logic          w_out_valid;

    assign w_transfer = bus.leaf_valid_i & w_leaf_ready;
    assign w_last     = (r_k == KW'(LEAVES - 1));

    // leaf_bits_i[1] lands on the even position u_2k, leaf_bits_i[0] on u_2k+1
    generate
        for (genvar gi = 0; gi < LEAVES; gi++) begin : g_leaf
            assign w_u_next[2*gi]   = (r_k == KW'(gi)) ? (bus.leaf_bits_i[1] & ~r_frozen[2*gi])
                                                       : r_u[2*gi];
            assign w_u_next[2*gi+1] = (r_k == KW'(gi)) ? (bus.leaf_bits_i[0] & ~r_frozen[2*gi+1])
                                                       : r_u[2*gi+1];
        end
    endgenerate

    polar_butterfly #(.N(N)) u_butterfly (
        .i_u (w_u_next),
        .o_x (w_x_next)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_leaf_ready = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) w_state_next = COLLECT;
            end
            COLLECT: begin
                w_leaf_ready = 1'b1;
                if (start_i) begin
                    w_state_next = COLLECT;
                end else if (w_transfer && w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_out_valid = 1'b1;
                // A start coinciding with the handshake still delivers this frame first
                if (start_i) begin
                    w_state_next = COLLECT;
                end else if (bus.out_ready_i) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_u      <= '0;
            r_k      <= '0;
            r_frozen <= '0;
            r_psum   <= '0;
        end else if (start_i) begin
            r_u      <= '0;
            r_k      <= '0;
            r_frozen <= frozen_i;
            r_psum   <= '0;
        end else if (w_transfer) begin
            r_u      <= w_u_next;
            r_psum   <= w_x_next;
            r_k      <= w_last ? '0 : r_k + KW'(1);
        end
    end

`ifdef FROZEN_CHECK_EN
    logic       r_err;
    logic [1:0] w_frozen_pair;
    logic       w_violation;

    assign w_frozen_pair = r_frozen[{r_k, 1'b0} +: 2];
    assign w_violation   = (bus.leaf_bits_i[1] & w_frozen_pair[0]) |
                           (bus.leaf_bits_i[0] & w_frozen_pair[1]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if (start_i) begin
            r_err <= 1'b0;
        end else if (w_transfer && w_violation) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

    assign bus.leaf_ready_o = w_leaf_ready;
    assign bus.out_valid_o  = w_out_valid;
    assign bus.u_o          = r_u;
    assign psum_o           = r_psum;
endmodule

// File: tb/tb_polar_psum_collector.sv
// Self-checking bench: directed N=8 scenarios plus randomized N=16 frames against a subset-XOR model.
module tb_polar_psum_collector;

`ifdef FROZEN_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        start8, err8;
    logic [7:0]  frozen8, psum8;
    logic        start16, err16;
    logic [15:0] frozen16, psum16;

    polar_psum_collector_if #(.N(8))  if8();
    polar_psum_collector_if #(.N(16)) if16();

    polar_psum_collector #(.N(8)) dut8 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start8), .frozen_i(frozen8),
        .bus(if8.slave), .psum_o(psum8), .err_o(err8)
    );

    polar_psum_collector #(.N(16)) dut16 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start16), .frozen_i(frozen16),
        .bus(if16.slave), .psum_o(psum16), .err_o(err16)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model of the N=8 frame in flight
    logic [7:0] m8_u, m8_fz;
    logic       m8_err;
    int         m8_k;

    // x_j = XOR of u_i over every i whose bit set contains j's
    function automatic logic [15:0] ref_x(input logic [15:0] u, input int n);
        logic [15:0] x = '0;
        for (int j = 0; j < n; j++)
            for (int i = 0; i < n; i++)
                if ((i & j) == j) x[j] = x[j] ^ u[i];
        return x;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame8(input logic [7:0] fz);
        start8 = 1'b1; frozen8 = fz;
        step();
        start8 = 1'b0;
        m8_u = '0; m8_k = 0; m8_fz = fz; m8_err = 1'b0;
    endtask

    task automatic leaf8(input logic [1:0] b);
        if8.leaf_valid_i = 1'b1; if8.leaf_bits_i = b;
        step();
        if8.leaf_valid_i = 1'b0;
        m8_u[2*m8_k]   = b[1] & ~m8_fz[2*m8_k];
        m8_u[2*m8_k+1] = b[0] & ~m8_fz[2*m8_k+1];
        if (CHK_EN && ((b[1] & m8_fz[2*m8_k]) || (b[0] & m8_fz[2*m8_k+1]))) m8_err = 1'b1;
        m8_k++;
    endtask

    task automatic handshake8();
        if8.out_ready_i = 1'b1;
        step();
        if8.out_ready_i = 1'b0;
        n_vec++;
        if (if8.out_valid_o !== 1'b0) begin
            n_err++; $display("FAIL handshake_idle: out_valid got %b want 0", if8.out_valid_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        n_vec++;
        if ({psum8, if8.u_o, if8.out_valid_o, if8.leaf_ready_o, err8} !== 19'd0) begin
            n_err++; $display("FAIL reset8: psum=%h u=%h ov=%b lr=%b err=%b want all 0",
                              psum8, if8.u_o, if8.out_valid_o, if8.leaf_ready_o, err8);
        end
        n_vec++;
        if ({psum16, if16.u_o, if16.out_valid_o, if16.leaf_ready_o, err16} !== 35'd0) begin
            n_err++; $display("FAIL reset16: psum=%h u=%h ov=%b lr=%b err=%b want all 0",
                              psum16, if16.u_o, if16.out_valid_o, if16.leaf_ready_o, err16);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_all_ones();
        logic [15:0] exp;
        start_frame8(8'h00);
        for (int i = 0; i < 4; i++) begin
            leaf8(2'b11);
            exp = ref_x({8'h00, m8_u}, 8);
            n_vec++;
            if (psum8 !== exp[7:0] || if8.out_valid_o !== (i == 3)) begin
                n_err++; $display("FAIL all_ones_leaf%0d: psum=%h ov=%b want psum=%h ov=%b",
                                  i, psum8, if8.out_valid_o, exp[7:0], (i == 3));
            end
        end
        n_vec++;
        if (if8.u_o !== 8'hFF || psum8 !== 8'h80) begin
            n_err++; $display("FAIL all_ones_final: u=%h psum=%h want u=ff psum=80", if8.u_o, psum8);
        end
        handshake8();
    endtask

    task automatic test_last_bit();
        logic [1:0] leaves [4] = '{2'b00, 2'b00, 2'b00, 2'b01};
        logic [7:0] exp_ps [4] = '{8'h00, 8'h00, 8'h00, 8'hFF};
        start_frame8(8'h00);
        for (int i = 0; i < 4; i++) begin
            leaf8(leaves[i]);
            n_vec++;
            if (psum8 !== exp_ps[i]) begin
                n_err++; $display("FAIL last_bit_psum%0d: got %h want %h", i, psum8, exp_ps[i]);
            end
        end
        n_vec++;
        if (if8.u_o !== 8'h80 || if8.out_valid_o !== 1'b1) begin
            n_err++; $display("FAIL last_bit_u: u=%h ov=%b want u=80 ov=1", if8.u_o, if8.out_valid_o);
        end
        handshake8();
    endtask

    task automatic test_frozen();
        start_frame8(8'h0F);
        leaf8(2'b11);
        n_vec++;
        if (err8 !== CHK_EN || psum8 !== 8'h00) begin
            n_err++; $display("FAIL frozen_first: err=%b psum=%h want err=%b psum=00", err8, psum8, CHK_EN);
        end
        for (int i = 0; i < 3; i++) leaf8(2'b00);
        n_vec++;
        if (if8.u_o !== 8'h00 || err8 !== m8_err || if8.out_valid_o !== 1'b1) begin
            n_err++; $display("FAIL frozen_final: u=%h err=%b ov=%b want u=00 err=%b ov=1",
                              if8.u_o, err8, if8.out_valid_o, m8_err);
        end
        handshake8();
    endtask

    task automatic test_backpressure();
        logic [15:0] exp;
        start_frame8(8'h00);
        for (int i = 0; i < 4; i++) leaf8(2'($urandom_range(0, 3)));
        exp = ref_x({8'h00, m8_u}, 8);
        for (int c = 0; c < 5; c++) begin
            if8.leaf_valid_i = 1'($urandom_range(0, 1));
            if8.leaf_bits_i  = 2'($urandom_range(0, 3));
            step();
            n_vec++;
            if (if8.out_valid_o !== 1'b1 || if8.u_o !== m8_u || if8.leaf_ready_o !== 1'b0 ||
                psum8 !== exp[7:0]) begin
                n_err++; $display("FAIL hold_cycle%0d: ov=%b u=%h lr=%b psum=%h want ov=1 u=%h lr=0 psum=%h",
                                  c, if8.out_valid_o, if8.u_o, if8.leaf_ready_o, psum8, m8_u, exp[7:0]);
            end
        end
        if8.leaf_valid_i = 1'b0;
        handshake8();
        step();
        n_vec++;
        if (if8.leaf_ready_o !== 1'b0 || if8.out_valid_o !== 1'b0) begin
            n_err++; $display("FAIL idle_after_release: lr=%b ov=%b want 0 0", if8.leaf_ready_o, if8.out_valid_o);
        end
    endtask

    task automatic test_restart();
        logic [15:0] exp;
        start_frame8(8'h00);
        leaf8(2'b10); leaf8(2'b10);
        exp = ref_x({8'h00, m8_u}, 8);
        n_vec++;
        if (if8.u_o !== 8'h05 || psum8 !== exp[7:0]) begin
            n_err++; $display("FAIL restart_pre: u=%h psum=%h want u=05 psum=%h", if8.u_o, psum8, exp[7:0]);
        end
        start_frame8(8'h00);
        n_vec++;
        if (psum8 !== 8'h00 || if8.leaf_ready_o !== 1'b1 || if8.out_valid_o !== 1'b0) begin
            n_err++; $display("FAIL restart_clear: psum=%h lr=%b ov=%b want 00 1 0", psum8, if8.leaf_ready_o, if8.out_valid_o);
        end
        leaf8(2'b01); leaf8(2'b00); leaf8(2'b00); leaf8(2'b00);
        n_vec++;
        if (if8.u_o !== 8'h02 || if8.out_valid_o !== 1'b1) begin
            n_err++; $display("FAIL restart_frame: u=%h ov=%b want 02 1", if8.u_o, if8.out_valid_o);
        end
        handshake8();
    endtask

    task automatic test_start_collisions();
        logic [15:0] exp;
        start_frame8(8'h00);
        for (int i = 0; i < 3; i++) leaf8(2'b11);
        // start together with the last leaf: leaf dropped, new frame begins
        if8.leaf_valid_i = 1'b1; if8.leaf_bits_i = 2'b11; start8 = 1'b1;
        step();
        if8.leaf_valid_i = 1'b0; start8 = 1'b0;
        m8_u = '0; m8_k = 0; m8_fz = 8'h00; m8_err = 1'b0;
        n_vec++;
        if (if8.out_valid_o !== 1'b0 || psum8 !== 8'h00 || if8.leaf_ready_o !== 1'b1) begin
            n_err++; $display("FAIL start_on_last: ov=%b psum=%h lr=%b want 0 00 1", if8.out_valid_o, psum8, if8.leaf_ready_o);
        end
        for (int i = 0; i < 4; i++) leaf8(2'($urandom_range(0, 3)));
        exp = ref_x({8'h00, m8_u}, 8);
        n_vec++;
        if (if8.out_valid_o !== 1'b1 || if8.u_o !== m8_u || psum8 !== exp[7:0]) begin
            n_err++; $display("FAIL collide_frame: ov=%b u=%h psum=%h want 1 %h %h",
                              if8.out_valid_o, if8.u_o, psum8, m8_u, exp[7:0]);
        end
        // start together with the DONE handshake: frame delivered, then COLLECT
        if8.out_ready_i = 1'b1; start8 = 1'b1; frozen8 = 8'h00;
        step();
        if8.out_ready_i = 1'b0; start8 = 1'b0;
        m8_u = '0; m8_k = 0;
        n_vec++;
        if (if8.out_valid_o !== 1'b0 || if8.leaf_ready_o !== 1'b1 || psum8 !== 8'h00) begin
            n_err++; $display("FAIL start_on_handshake: ov=%b lr=%b psum=%h want 0 1 00", if8.out_valid_o, if8.leaf_ready_o, psum8);
        end
        for (int i = 0; i < 4; i++) leaf8(2'b00);
        handshake8();
    endtask

    task automatic test_async_reset();
        start_frame8(8'h00);
        leaf8(2'b11); leaf8(2'b11);
        #3;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({psum8, if8.u_o, if8.out_valid_o, if8.leaf_ready_o, err8} !== 19'd0) begin
            n_err++; $display("FAIL async_reset: psum=%h u=%h ov=%b lr=%b err=%b want all 0",
                              psum8, if8.u_o, if8.out_valid_o, if8.leaf_ready_o, err8);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_random16();
        logic [15:0] u, fz, exp;
        logic        e, v;
        logic [1:0]  b;
        int          k, budget;
        for (int f = 0; f < 20; f++) begin
            fz = 16'($urandom) & 16'($urandom);
            start16 = 1'b1; frozen16 = fz;
            step();
            start16 = 1'b0;
            u = '0; e = 1'b0; k = 0; budget = 0;
            while (k < 8 && budget < 100) begin
                v = 1'($urandom_range(0, 2) != 0);
                b = 2'($urandom_range(0, 3));
                if16.leaf_valid_i = v; if16.leaf_bits_i = b;
                step();
                budget++;
                if (v) begin
                    u[2*k]   = b[1] & ~fz[2*k];
                    u[2*k+1] = b[0] & ~fz[2*k+1];
                    if (CHK_EN && ((b[1] & fz[2*k]) || (b[0] & fz[2*k+1]))) e = 1'b1;
                    k++;
                end
                exp = ref_x(u, 16);
                n_vec++;
                if (psum16 !== exp || if16.out_valid_o !== (k == 8) || err16 !== e) begin
                    n_err++; $display("FAIL rand16_f%0d_k%0d: psum=%h ov=%b err=%b want %h %b %b",
                                      f, k, psum16, if16.out_valid_o, err16, exp, (k == 8), e);
                end
            end
            if16.leaf_valid_i = 1'b0;
            n_vec++;
            if (if16.u_o !== u) begin
                n_err++; $display("FAIL rand16_u_f%0d: got %h want %h", f, if16.u_o, u);
            end
            budget = 0;
            do begin
                v = (budget > 5) ? 1'b1 : 1'($urandom_range(0, 1));
                if16.out_ready_i = v;
                step();
                budget++;
            end while (!v);
            if16.out_ready_i = 1'b0;
            n_vec++;
            if (if16.out_valid_o !== 1'b0) begin
                n_err++; $display("FAIL rand16_release_f%0d: ov=%b want 0", f, if16.out_valid_o);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        start8 = 1'b0; frozen8 = '0; start16 = 1'b0; frozen16 = '0;
        if8.leaf_valid_i = 1'b0;  if8.leaf_bits_i = '0;  if8.out_ready_i = 1'b0;
        if16.leaf_valid_i = 1'b0; if16.leaf_bits_i = '0; if16.out_ready_i = 1'b0;
        m8_u = '0; m8_fz = '0; m8_err = 1'b0; m8_k = 0;
        rst_n = 1'b1;
        #1;
        test_reset();
        test_all_ones();
        test_last_bit();
        test_frozen();
        test_backpressure();
        test_restart();
        test_start_collisions();
        test_async_reset();
        test_random16();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
